// File: rtl/video_out_align_if.sv
// Pixel/sync bus between the palette mixer, the video output aligner and the DAC/encoder side.
// The slave modport is the aligner's view; the master modport is the driver/observer side.
interface video_out_align_if;
  logic [3:0]  pc_ena_in;
  logic [7:0]  pixel_in_r;
  logic [7:0]  pixel_in_g;
  logic [7:0]  pixel_in_b;
  logic        hs_in;
  logic        vs_in;
  logic        de_in;
  logic        testpat_ena;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic        frame_start;
  logic [11:0] active_width;
  logic [11:0] active_lines;

  modport master (
    output pc_ena_in, pixel_in_r, pixel_in_g, pixel_in_b, hs_in, vs_in, de_in, testpat_ena,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start, active_width, active_lines
  );

  modport slave (
    input  pc_ena_in, pixel_in_r, pixel_in_g, pixel_in_b, hs_in, vs_in, de_in, testpat_ena,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start, active_width, active_lines
  );
endinterface

// File: rtl/video_out_align.sv
// Final video output stage: delays hs/vs/de to match the mixer's RGB pipeline, blanks and registers
// the output bus, and measures active width/height. Colour bars are built when VIDEO_TESTPAT_EN is defined.
module video_out_align #(
  parameter int SYNC_DELAY = 3,
  parameter int BAR_WIDTH  = 80
) (
  input logic             clk,
  input logic             reset,
  video_out_align_if.slave vif
);

  logic        tick;
  logic [2:0]  dly [SYNC_DELAY];
  logic        hs_d, vs_d, de_d;
  logic        de_prev, vs_prev;
  logic        de_fall, vs_rise;
  logic [11:0] h_cnt;
  logic [11:0] line_cnt;
  logic [11:0] line_next;
  logic [23:0] pix_sel;

  assign tick              = (vif.pc_ena_in == 4'd0);
  assign {hs_d, vs_d, de_d} = dly[SYNC_DELAY-1];
  assign de_fall           = de_prev & ~de_d;
  assign vs_rise           = ~vs_prev & vs_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_DELAY; i++) dly[i] <= 3'b000;
    end else if (tick) begin
      dly[0] <= {vif.hs_in, vif.vs_in, vif.de_in};
      for (int i = 1; i < SYNC_DELAY; i++) dly[i] <= dly[i-1];
    end
  end

  // A line ending on the same tick as a frame start still counts toward that frame.
  always_comb begin
    line_next = line_cnt;
    if (de_fall && line_cnt != 12'hFFF) line_next = line_cnt + 12'd1;
  end

`ifdef VIDEO_TESTPAT_EN
  localparam logic [11:0] BAR_LAST = 12'(BAR_WIDTH - 1);

  logic [11:0] bar_cnt;
  logic [2:0]  bar_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_cnt <= 12'd0;
      bar_idx <= 3'd0;
    end else if (tick) begin
      if (de_fall) begin
        bar_cnt <= 12'd0;
        bar_idx <= 3'd0;
      end else if (de_d) begin
        if (bar_cnt == BAR_LAST) begin
          bar_cnt <= 12'd0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + 12'd1;
        end
      end
    end
  end

  // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
  always_comb begin
    pix_sel = {vif.pixel_in_r, vif.pixel_in_g, vif.pixel_in_b};
    if (vif.testpat_ena) pix_sel = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
  end
`else
  logic        unused_testpat;
  logic [11:0] unused_bar_width;

  assign unused_testpat   = vif.testpat_ena;
  assign unused_bar_width = 12'(BAR_WIDTH);
  assign pix_sel          = {vif.pixel_in_r, vif.pixel_in_g, vif.pixel_in_b};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vif.vga_r        <= 8'd0;
      vif.vga_g        <= 8'd0;
      vif.vga_b        <= 8'd0;
      vif.vga_hs       <= 1'b0;
      vif.vga_vs       <= 1'b0;
      vif.vga_de       <= 1'b0;
      vif.frame_start  <= 1'b0;
      vif.active_width <= 12'd0;
      vif.active_lines <= 12'd0;
      de_prev          <= 1'b0;
      vs_prev          <= 1'b0;
      h_cnt            <= 12'd0;
      line_cnt         <= 12'd0;
    end else begin
      vif.frame_start <= 1'b0;
      if (tick) begin
        vif.vga_hs <= hs_d;
        vif.vga_vs <= vs_d;
        vif.vga_de <= de_d;
        {vif.vga_r, vif.vga_g, vif.vga_b} <= de_d ? pix_sel : 24'd0;
        de_prev <= de_d;
        vs_prev <= vs_d;
        if (de_fall) begin
          vif.active_width <= h_cnt;
          h_cnt            <= 12'd0;
        end else if (de_d && h_cnt != 12'hFFF) begin
          h_cnt <= h_cnt + 12'd1;
        end
        if (vs_rise) begin
          vif.active_lines <= line_next;
          line_cnt         <= 12'd0;
          vif.frame_start  <= 1'b1;
        end else begin
          line_cnt <= line_next;
        end
      end
    end
  end

endmodule

// File: doc/video_out_align.md
Name: video_out_align

Overview:
- Final video output stage, directly downstream of the palette mixer's 24-bit RGB output.
- Delays raster sync and data-enable (hs/vs/de) by a programmable number of pixel ticks so they line up with the mixer's pipelined RGB.
- Blanks RGB outside active video and registers everything as the DAC/HDMI-encoder output bus.
- Measures active width and height per frame for host/debug status.

Parameters:
SYNC_DELAY, 3, pixel-tick delay applied to hs/vs/de; legal range 1..15.
BAR_WIDTH, 80, test-pattern bar width in active pixels; legal range 1..4095.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous active-high reset
pc_ena_in  in  4  pixel clock-enable phase; pixel tick when pc_ena_in==0
pixel_in_r  in  8  red from palette mixer
pixel_in_g  in  8  green from palette mixer
pixel_in_b  in  8  blue from palette mixer
hs_in  in  1  raw hsync, active-high
vs_in  in  1  raw vsync, active-high
de_in  in  1  raw data enable, active-high
testpat_ena  in  1  test pattern request; ignored unless VIDEO_TESTPAT_EN
vga_r  out  8  red output
vga_g  out  8  green output
vga_b  out  8  blue output
vga_hs  out  1  delayed hsync
vga_vs  out  1  delayed vsync
vga_de  out  1  delayed data enable
frame_start  out  1  one-clk pulse on delayed vs rising edge
active_width  out  12  active pixels in last completed line
active_lines  out  12  active lines in last completed frame

Behaviour:
- Reset (async, reset=1): every output = 0, delay-line stages = 0, all counters = 0. Release takes effect at the next clk edge.
- tick = (pc_ena_in==4'd0). All state except frame_start's clear changes only on clk edges where tick=1. Outputs hold between ticks.
- Delay line: SYNC_DELAY stages of {hs,vs,de}, shifted each tick.
  - Delayed signals (hs_d, vs_d, de_d) are registered to vga_hs/vs/de.
  - hs_in sampled at tick N appears on vga_hs after tick N+SYNC_DELAY. Same for vs and de.
- RGB path: pixel_in_* sampled at tick M is registered to vga_* at tick M, gated by de_d of the same tick.
  - If de_d=0, vga_r/g/b = 0.
  - Upstream must present a pixel SYNC_DELAY ticks after its de_in.
- h_cnt (12-bit):
  - Increments each tick with de_d=1 and saturates at 4095.
  - On the de_d 1->0 tick: active_width <= h_cnt and h_cnt <= 0.
- line_cnt (12-bit):
  - Increments on the de_d 1->0 tick and saturates at 4095.
  - On the vs_d 0->1 tick: active_lines <= line_cnt, line_cnt <= 0, and frame_start = 1 for that clk only. It is cleared on the next clk edge regardless of tick.
- Simultaneous de_d fall and vs_d rise on the same tick: line_cnt increments first. active_lines latches the incremented value, then line_cnt clears.
- Edge detection uses the previous-tick values of de_d/vs_d, held in registers that reset to 0.
  - de_in held high through reset release is not counted as a falling edge.
  - The first frame after reset may report a partial active_lines. No error flag is raised.
- pc_ena_in never 0: outputs and counters frozen.

Optional Feature:
- Macro VIDEO_TESTPAT_EN.
- Defined, testpat_ena=1 and de_d=1: RGB replaced by 8 colour bars, sampled per tick like normal pixels.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is 8'hFF or 8'h00.
  - Bar index advances every BAR_WIDTH active pixels, counted with a bar pixel counter, not a divider.
  - Index wraps 7->0. Bar counter and index reset to 0 on the de_d 1->0 tick.
  - Sync timing and counters are unchanged.
- Undefined: testpat_ena is ignored, and no bar-counter logic is synthesised.

Test Plan:
- SYNC_DELAY=3, pc_ena_in cycling 0..3: pulse hs_in for 1 tick at tick 10 -> vga_hs high after tick 13 for exactly 4 clks.
- de_in high 640 ticks, pixel_in=24'h123456 constant -> vga_rgb 123456 only while vga_de=1, 0 otherwise; active_width=640 after the line ends.
- 480 lines of 640 active pixels, then vs_in rise -> one 1-clk frame_start; active_lines=480; line_cnt restarts at 0.
- de fall and vs rise delayed onto the same tick after 479 lines -> active_lines=480.
- Assert reset mid-line (h_cnt=200) -> all outputs 0 immediately; after release, next full line reports active_width=640.
- VIDEO_TESTPAT_EN defined, BAR_WIDTH=80, testpat_ena=1, 640-pixel line -> pixels 0..79 FFFFFF, 80..159 FFFF00, ..., 560..639 000000.
